alu_wide: RTL
=============

Name: alu_wide

Overview:
- Parametrised successor to the 8-bit accumulator ALU. Single accumulator of WIDTH bits, executing one instruction per inst_wen strobe.
- Adds carry/zero flags, carry-in arithmetic, compare, barrel shifts and an optional multi-cycle multiply with a busy indication.
- Sits behind the controller's instruction bus. Error state is sticky until reset.

Parameters:
- WIDTH, 8, accumulator/immediate width in bits (>=4).
- SHW, 4, shift-amount field width; amount taken from imm[SHW-1:0].

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- inst  in  4+WIDTH  {opcode[3:0], imm[WIDTH-1:0]}.
- inst_wen  in  1  instruction strobe, sampled on the rising edge.
- result  out  WIDTH  accumulator value.
- carry  out  1  carry/borrow flag.
- zero  out  1  set when the accumulator equals 0.
- busy  out  1  multi-cycle operation in progress.
- error  out  1  invalid opcode seen; sticky.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports named clock and reset.
- Reset values: result=0, carry=0, zero=0, busy=0, error=0. State goes to READY.
- Reset has priority over everything and aborts an in-flight MUL.
- States:
  - READY: accepts instructions.
  - MUL: shift-add multiply in progress.
  - ERROR: ignores all instructions.
- Accept rule: inst is accepted on a rising edge with inst_wen=1 in READY. Updated result and flags are visible after that same edge (1-cycle latency).
- inst_wen in MUL or ERROR is ignored; nothing is queued.
- A level-held inst_wen re-executes the instruction on every edge (same as the predecessor).
- Opcodes (acc = accumulator, C = carry):
  - 0 NOP: no change.
  - 1 LDI: acc=imm; C=0.
  - 2 ADD: {C,acc}=acc+imm.
  - 3 SUB: acc=acc-imm; C=1 on borrow.
  - 4 NOT: acc=~acc; C unchanged.
  - 5 AND: acc&imm; C unchanged.
  - 6 IOR: acc|imm; C unchanged.
  - 7 XOR: acc^imm; C unchanged.
  - 8 SHL: acc<<n, n=imm[SHW-1:0]. C=last bit shifted out (0 if n=0). n>=WIDTH gives acc=0, and C=0 if n>WIDTH.
  - 9 SHR: logical right shift, same rules as SHL.
  - A ADC: {C,acc}=acc+imm+C.
  - B SBC: acc=acc-imm-C; C=borrow.
  - C MUL: acc=low WIDTH bits of acc*imm. C=1 if the high half is nonzero.
  - D CMP: flags as SUB; acc unchanged.
  - E, F: invalid; go to ERROR.
- zero is recomputed whenever acc (or the CMP difference) is written. NOP leaves it unchanged.
- Wrap-around: all arithmetic is modulo 2^WIDTH.
- ERROR:
  - error=1, result holds its last value, busy=0.
  - Only reset exits ERROR.
- MUL sequencing:
  - On accept: busy=1, multiplicand and multiplier are latched, iteration counter=0.
  - One shift-add step per cycle for WIDTH cycles.
  - On the edge completing step WIDTH: acc and C are written, busy=0, state returns to READY.
  - The next instruction is accepted on the following edge.
  - Total latency is WIDTH+1 edges from accept to READY. result holds the old acc while busy=1.

Optional Feature:
- ALU_WIDE_MUL_EN defined: MUL (opcode C) is implemented as above and busy can assert.
- ALU_WIDE_MUL_EN undefined:
  - Opcode C is invalid and goes to ERROR.
  - The MUL state and datapath are absent; busy is tied to 0.

Test Plan (WIDTH=8, SHW=4):
- LDI 1A; ADD 01; SUB 02 -> result 1A, 1B, 19; carry 0; zero 0.
- LDI FF; ADD 01; ADC 00 -> result 00 with carry=1, zero=1; then result 01 with carry=0, zero=0.
- LDI 00; SUB 01; SBC 00 -> FF with carry=1; then FE with carry=0.
- LDI 81; SHL 01 -> 02, carry=1. SHR 09 -> 00, carry=0, zero=1. LDI 0F; CMP 0F -> result 0F, zero=1, carry=0.
- (ALU_WIDE_MUL_EN) LDI 12; MUL 10 -> busy high 8 cycles, then result 20, carry=1. ADD 01 issued while busy is ignored; ADD 01 after busy falls gives 21.
- Opcode F -> error=1, result unchanged; a following LDI AA is ignored. Reset -> all outputs 0; LDI AA -> result AA. Reset asserted mid-MUL -> busy=0, result 0.

Source files
------------

// File: rtl/alu_wide.sv
// Parametrised accumulator ALU with carry/zero flags, barrel shifts and sticky error state.
// Optional shift-add multiply (opcode C) is built only when ALU_WIDE_MUL_EN is defined.
module alu_wide #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH+3:0] inst,
  input  logic             inst_wen,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             error
);

  localparam logic [3:0] OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_NOT = 4'h4,
                         OP_AND = 4'h5, OP_IOR = 4'h6, OP_XOR = 4'h7, OP_SHL = 4'h8,
                         OP_SHR = 4'h9, OP_ADC = 4'hA, OP_SBC = 4'hB, OP_MUL = 4'hC,
                         OP_CMP = 4'hD;

`ifdef ALU_WIDE_MUL_EN
  typedef enum logic [1:0] {S_READY = 2'd0, S_MUL = 2'd1, S_ERROR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_READY = 2'd0, S_ERROR = 2'd2} state_t;
`endif

  state_t           state, state_nx;
  logic [3:0]       op;
  logic [WIDTH-1:0] imm, acc, acc_nx;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   t;
  logic             c_nx, z_nx, acc_wr, op_bad, accept;

  assign op     = inst[WIDTH+3:WIDTH];
  assign imm    = inst[WIDTH-1:0];
  assign sh     = imm[SHW-1:0];
  assign accept = (state == S_READY) && inst_wen;
`ifdef ALU_WIDE_MUL_EN
  assign op_bad = (op == 4'hE) || (op == 4'hF);
`else
  assign op_bad = (op == 4'hE) || (op == 4'hF) || (op == OP_MUL);
`endif

  // single-cycle ops; t carries the (W+1)-bit intermediate so the top bit is carry/borrow
  always_comb begin
    acc_nx = acc;
    c_nx   = carry;
    acc_wr = 1'b1;
    t      = '0;
    case (op)
      OP_LDI: begin acc_nx = imm; c_nx = 1'b0; end
      OP_ADD: begin t = {1'b0, acc} + {1'b0, imm}; {c_nx, acc_nx} = t; end
      OP_SUB: begin t = {1'b0, acc} - {1'b0, imm}; {c_nx, acc_nx} = t; end
      OP_NOT: acc_nx = ~acc;
      OP_AND: acc_nx = acc & imm;
      OP_IOR: acc_nx = acc | imm;
      OP_XOR: acc_nx = acc ^ imm;
      OP_SHL: {c_nx, acc_nx} = {1'b0, acc} << sh;
      OP_SHR: {acc_nx, c_nx} = {acc, 1'b0} >> sh;
      OP_ADC: begin
        t = {1'b0, acc} + {1'b0, imm} + {{WIDTH{1'b0}}, carry};
        {c_nx, acc_nx} = t;
      end
      OP_SBC: begin
        t = {1'b0, acc} - {1'b0, imm} - {{WIDTH{1'b0}}, carry};
        {c_nx, acc_nx} = t;
      end
      OP_CMP: begin t = {1'b0, acc} - {1'b0, imm}; c_nx = t[WIDTH]; acc_wr = 1'b0; end
      default: acc_wr = 1'b0;
    endcase
    z_nx = (op == OP_CMP) ? (t[WIDTH-1:0] == '0) : (acc_wr ? (acc_nx == '0) : zero);
  end

`ifdef ALU_WIDE_MUL_EN
  localparam int CW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] mcand, prod, prod_nx;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               last_step;

  assign prod_nx   = mplier[0] ? prod + mcand : prod;
  assign last_step = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (accept && op == OP_MUL) begin
      mcand  <= {{WIDTH{1'b0}}, acc};
      mplier <= imm;
      prod   <= '0;
      cnt    <= '0;
    end else if (state == S_MUL) begin
      prod   <= prod_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= S_READY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_READY: begin
        if (inst_wen) begin
          if (op_bad) state_nx = S_ERROR;
`ifdef ALU_WIDE_MUL_EN
          else if (op == OP_MUL) state_nx = S_MUL;
`endif
        end
      end
`ifdef ALU_WIDE_MUL_EN
      S_MUL: if (last_step) state_nx = S_READY;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc   <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else begin
      if (accept) begin
        acc   <= acc_nx;
        carry <= c_nx;
        zero  <= z_nx;
      end
`ifdef ALU_WIDE_MUL_EN
      if (state == S_MUL && last_step) begin
        acc   <= prod_nx[WIDTH-1:0];
        carry <= |prod_nx[2*WIDTH-1:WIDTH];
        zero  <= (prod_nx[WIDTH-1:0] == '0);
      end
`endif
    end
  end

  assign result = acc;
  assign error  = (state == S_ERROR);
`ifdef ALU_WIDE_MUL_EN
  assign busy   = (state == S_MUL);
`else
  assign busy   = 1'b0;
`endif

endmodule
